// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the 4-bit CPU front end: PC width, phase encodings,
// sequencer state encoding and the opcode map used by fetch and decode.
package cpu_fetch_pkg;

    localparam int unsigned PC_W = 12;

    // Phase bit as seen by the decoder
    localparam logic PH_FETCH = 1'b0;
    localparam logic PH_EXEC  = 1'b1;

    // HALT is only reachable when the breakpoint feature is built in
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    // Opcode map (IR[7:4])
    localparam logic [3:0] OP_JC    = 4'h0;
    localparam logic [3:0] OP_JNC   = 4'h1;
    localparam logic [3:0] OP_CMPI  = 4'h2;
    localparam logic [3:0] OP_CMPM  = 4'h3;
    localparam logic [3:0] OP_LIT   = 4'h4;
    localparam logic [3:0] OP_IN    = 4'h5;
    localparam logic [3:0] OP_LD    = 4'h6;
    localparam logic [3:0] OP_ST    = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;
    localparam logic [3:0] OP_ADDI  = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_OUT   = 4'hD;
    localparam logic [3:0] OP_NANI  = 4'hE;
    localparam logic [3:0] OP_NANDM = 4'hF;

endpackage

// File: rtl/rom_wait_timer.sv
// ROM wait-state counter. Counts 0..ROM_WAIT inside each phase and flags the
// last cycle as phase_end. With run low the count parks at ROM_WAIT, so the
// sequencer freezes on a phase boundary and resumes with phase_end at once.
module rom_wait_timer #(
    parameter int unsigned ROM_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic hold,
    output logic phase_end
);

    // ROM_WAIT is limited to 0..7 by the counter width
    localparam logic [2:0] LastCnt = 3'(ROM_WAIT);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic       last;

    assign last = (cnt_q == LastCnt);

    // Next count: restart after the last cycle only when running; hold clears
    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = 3'd0;
        end else if (!last) begin
            cnt_d = cnt_q + 3'd1;
        end else if (run) begin
            cnt_d = 3'd0;
        end
    end

    // Strobe is suppressed while reset is asserted so no load is qualified
    always_comb begin
        phase_end = run && last && !hold && !reset;
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 4-bit CPU: owns PC, fetch/exec phase, instruction
// register and ROM address; advances on the decoder's inc_pc / load_pc at
// each phase_end.
// Optional build macro FETCH_BREAKPOINT_EN adds a PC breakpoint with a HALT
// state and the bp_en / bp_addr / bp_resume / bp_hit ports.
module fetch_sequencer #(
    parameter int unsigned        PC_W         = cpu_fetch_pkg::PC_W,
    parameter int unsigned        ROM_WAIT     = 0,
    parameter logic [PC_W-1:0]    RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    input  logic            inc_pc,
    input  logic            load_pc,
    output logic            phase,
    output logic [3:0]      instr,
    output logic [3:0]      imm,
    output logic [11:0]     oprnd_addr,
    output logic            phase_end,
`ifdef FETCH_BREAKPOINT_EN
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            bp_resume,
    output logic            bp_hit,
`endif
    output logic [PC_W-1:0] pc
);

    import cpu_fetch_pkg::*;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] jump_target;
    logic [7:0]      ir_q;
    logic [7:0]      ir_d;
    logic            halted;

    assign halted = (state_q == HALT);

    rom_wait_timer #(
        .ROM_WAIT (ROM_WAIT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .hold      (halted),
        .phase_end (phase_end)
    );

    // Wraps modulo 2^PC_W; jump target is truncated/extended to PC width
    assign pc_inc      = pc_q + PC_W'(1);
    assign jump_target = PC_W'(oprnd_addr);

    // Next-state: all updates happen only on phase_end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            FETCH: begin
                if (phase_end) begin
                    ir_d    = rom_data;
                    state_d = EXEC;
                    if (inc_pc) begin
                        pc_d = pc_inc;
                    end
                end
            end
            EXEC: begin
                if (phase_end) begin
                    state_d = FETCH;
                    if (load_pc) begin
                        pc_d = jump_target;
                    end else if (inc_pc) begin
                        pc_d = pc_inc;
                    end
`ifdef FETCH_BREAKPOINT_EN
                    // Breakpoint is checked only on entry to FETCH, so a
                    // resume from HALT fetches the trapped address once
                    if (bp_en && (pc_d == bp_addr)) begin
                        state_d = HALT;
                    end
`endif
                end
            end
            HALT: begin
`ifdef FETCH_BREAKPOINT_EN
                if (bp_resume) begin
                    state_d = FETCH;
                end
`else
                state_d = FETCH;
`endif
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC and IR registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs; HALT presents the FETCH phase to the decoder
    always_comb begin
        phase      = (state_q == EXEC) ? PH_EXEC : PH_FETCH;
        instr      = ir_q[7:4];
        imm        = ir_q[3:0];
        oprnd_addr = {ir_q[3:0], rom_data};
        rom_addr   = pc_q;
        pc         = pc_q;
    end

`ifdef FETCH_BREAKPOINT_EN
    assign bp_hit = halted;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: one instance with ROM_WAIT = 0 and
// one with ROM_WAIT = 2. Drivers push the expected post-phase state; monitors
// pop and compare after every clock edge that carried phase_end.
module tb_fetch_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] pc;
        logic        ph;
        logic [7:0]  ir;
    } exp_t;

    typedef struct packed {
        logic [7:0]  rom;
        logic        inc;
        logic        load;
        logic [11:0] pc;
        logic        ph;
        logic [7:0]  ir;
    } vec_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    // Instance A: ROM_WAIT = 0, reset vector 0
    logic        a_run = 1'b0, a_inc = 1'b0, a_load = 1'b0;
    logic [7:0]  a_rom = 8'h00;
    logic [11:0] a_rom_addr, a_oprnd, a_pc;
    logic        a_phase, a_pe;
    logic [3:0]  a_instr, a_imm;

    // Instance B: ROM_WAIT = 2, reset vector 0x010
    logic        b_run = 1'b0, b_inc = 1'b0, b_load = 1'b0;
    logic [7:0]  b_rom = 8'h00;
    logic [11:0] b_rom_addr, b_oprnd, b_pc;
    logic        b_phase, b_pe;
    logic [3:0]  b_instr, b_imm;

`ifdef FETCH_BREAKPOINT_EN
    logic a_bp_hit, b_bp_hit;
`endif

    fetch_sequencer #(
        .PC_W         (12),
        .ROM_WAIT     (0),
        .RESET_VECTOR (12'h000)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .run        (a_run),
        .rom_addr   (a_rom_addr),
        .rom_data   (a_rom),
        .inc_pc     (a_inc),
        .load_pc    (a_load),
        .phase      (a_phase),
        .instr      (a_instr),
        .imm        (a_imm),
        .oprnd_addr (a_oprnd),
        .phase_end  (a_pe),
`ifdef FETCH_BREAKPOINT_EN
        .bp_en      (1'b0),
        .bp_addr    (12'h000),
        .bp_resume  (1'b0),
        .bp_hit     (a_bp_hit),
`endif
        .pc         (a_pc)
    );

    fetch_sequencer #(
        .PC_W         (12),
        .ROM_WAIT     (2),
        .RESET_VECTOR (12'h010)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .run        (b_run),
        .rom_addr   (b_rom_addr),
        .rom_data   (b_rom),
        .inc_pc     (b_inc),
        .load_pc    (b_load),
        .phase      (b_phase),
        .instr      (b_instr),
        .imm        (b_imm),
        .oprnd_addr (b_oprnd),
        .phase_end  (b_pe),
`ifdef FETCH_BREAKPOINT_EN
        .bp_en      (1'b0),
        .bp_addr    (12'h000),
        .bp_resume  (1'b0),
        .bp_hit     (b_bp_hit),
`endif
        .pc         (b_pc)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor A: compare post-edge state for every phase_end
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_pe && !reset) begin
                @(posedge clk);
                #1;
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected_phase_end: got pc=%0h expected no phase_end",
                             a_pc);
                end else begin
                    e = q_a.pop_front();
                    check("a_pc", 32'(a_pc), 32'(e.pc));
                    check("a_phase", 32'(a_phase), 32'(e.ph));
                    check("a_ir", 32'({a_instr, a_imm}), 32'(e.ir));
                end
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_pe && !reset) begin
                @(posedge clk);
                #1;
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_phase_end: got pc=%0h expected no phase_end",
                             b_pc);
                end else begin
                    e = q_b.pop_front();
                    check("b_pc", 32'(b_pc), 32'(e.pc));
                    check("b_phase", 32'(b_phase), 32'(e.ph));
                    check("b_ir", 32'({b_instr, b_imm}), 32'(e.ir));
                end
            end
        end
    end

    // Drive one phase on A and wait for its phase_end edge
    task automatic a_step(input vec_t v);
        bit seen;
        seen   = 1'b0;
        a_run  = 1'b1;
        a_rom  = v.rom;
        a_inc  = v.inc;
        a_load = v.load;
        q_a.push_back(exp_t'{v.pc, v.ph, v.ir});
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = a_pe;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL a_phase_end_timeout: got no phase_end expected one");
        end
        @(posedge clk);
        #3;
    endtask

    // Drive one phase on B; inc_pc is pulsed on every non-end cycle
    task automatic b_step(input vec_t v, input int cyc_e);
        bit          seen;
        int          cycles;
        logic [11:0] pc0;
        seen   = 1'b0;
        cycles = 0;
        pc0    = b_pc;
        b_run  = 1'b1;
        b_rom  = v.rom;
        b_load = v.load;
        b_inc  = 1'b1;
        q_b.push_back(exp_t'{v.pc, v.ph, v.ir});
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            seen  = b_pe;
            b_inc = seen ? v.inc : 1'b1;
            if (!seen) check("b_pc_hold_mid_phase", 32'(b_pc), 32'(pc0));
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL b_phase_end_timeout: got no phase_end expected one");
        end
        check("b_phase_length", 32'(cycles), 32'(cyc_e));
        @(posedge clk);
        #3;
        b_inc = 1'b0;
    endtask

    vec_t a_vec [11] = '{
        '{8'h4A, 1'b1, 1'b0, 12'h001, 1'b1, 8'h4A},  // LIT A fetch
        '{8'h00, 1'b0, 1'b0, 12'h001, 1'b0, 8'h4A},  // single-byte exec
        '{8'hC3, 1'b1, 1'b0, 12'h002, 1'b1, 8'hC3},  // JMP fetch
        '{8'h5E, 1'b1, 1'b1, 12'h35E, 1'b0, 8'hC3},  // JMP 35E, load beats inc
        '{8'hCF, 1'b1, 1'b0, 12'h35F, 1'b1, 8'hCF},
        '{8'hFF, 1'b0, 1'b1, 12'hFFF, 1'b0, 8'hCF},  // jump to FFF
        '{8'h71, 1'b1, 1'b0, 12'h000, 1'b1, 8'h71},  // wrap FFF -> 000
        '{8'h20, 1'b1, 1'b0, 12'h001, 1'b0, 8'h71},  // ST exec with inc
        '{8'hA5, 1'b0, 1'b1, 12'h001, 1'b1, 8'hA5},  // load ignored in fetch
        '{8'h00, 1'b0, 1'b1, 12'h500, 1'b0, 8'hA5},  // load without inc
        '{8'h12, 1'b1, 1'b0, 12'h501, 1'b1, 8'h12}   // now mid-EXEC
    };

    initial begin
        #1 reset = 1'b1;
        a_run = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("a_reset_phase_end", 32'(a_pe), 32'h0);
        check("a_reset_pc", 32'(a_pc), 32'h000);
        check("a_reset_phase", 32'(a_phase), 32'h0);
        check("a_reset_instr", 32'(a_instr), 32'h0);
        check("a_reset_imm", 32'(a_imm), 32'h0);
        check("b_reset_pc", 32'(b_pc), 32'h010);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            if (i == 3) begin
                a_rom = 8'h5E;
                #1;
                check("a_oprnd_addr", 32'(a_oprnd), 32'h35E);
                check("a_rom_addr", 32'(a_rom_addr), 32'h002);
            end
            a_step(a_vec[i]);
        end

        // Async reset between edges while in EXEC at pc 0x501
        a_run = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("a_async_reset_pc", 32'(a_pc), 32'h000);
        check("a_async_reset_phase", 32'(a_phase), 32'h0);
        check("a_async_reset_instr", 32'(a_instr), 32'h0);
        check("a_async_reset_rom_addr", 32'(a_rom_addr), 32'h000);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("a_frozen_after_reset_pc", 32'(a_pc), 32'h000);

        // B: counter parked at ROM_WAIT, so first phase ends at once
        b_step('{8'h4A, 1'b1, 1'b0, 12'h011, 1'b1, 8'h4A}, 1);
        b_step('{8'h00, 1'b0, 1'b0, 12'h011, 1'b0, 8'h4A}, 3);
        b_step('{8'h72, 1'b1, 1'b0, 12'h012, 1'b1, 8'h72}, 3);

        // Freeze during EXEC
        b_run = 1'b0;
        b_inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_freeze_phase_end", 32'(b_pe), 32'h0);
            check("b_freeze_pc", 32'(b_pc), 32'h012);
            check("b_freeze_phase", 32'(b_phase), 32'h1);
        end
        @(posedge clk);
        #3;
        b_step('{8'h00, 1'b1, 1'b0, 12'h013, 1'b0, 8'h72}, 1);
        b_run = 1'b0;

        repeat (4) @(posedge clk);
        #3;
        check("a_queue_drained", 32'(q_a.size()), 32'h0);
        check("b_queue_drained", 32'(q_b.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
